// File: rtl/crc_packet_ctrl.sv
// crc_packet_ctrl: buffers a length-prefixed byte packet and streams it MSB-first, zero-augmented, into a serial CRC engine
module crc_packet_ctrl #(
    parameter int MAX_BYTES    = 16,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [7:0]  i_in_byte,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic        o_crc_start,
    output logic        o_crc_data,
    input  logic        i_crc_done,
    input  logic [15:0] i_crc_r,
    output logic [15:0] o_result,
    output logic        o_err_len,
    output logic        o_err_timeout,
    output logic        o_result_valid,
    input  logic        i_result_ready
);
    localparam int NBITS = 8 * (MAX_BYTES + 1);
    localparam int CW    = $clog2((NBITS > DONE_TIMEOUT ? NBITS : DONE_TIMEOUT) + 17);
    localparam int IW    = MAX_BYTES > 1 ? $clog2(MAX_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_DRAIN, S_START, S_SHIFT, S_PAD, S_WAIT, S_RESULT
    } state_t;

    state_t        r_state, w_next;
    logic [7:0]    r_len, r_idx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [7:0]    r_buf [MAX_BYTES];
    logic          r_data, r_err_len, r_err_to;
    logic [15:0]   r_result;
    logic          w_xfer, w_last_byte, w_last_bit, w_timeout, w_count;
    logic [CW-4:0] w_bsel;
    logic [7:0]    w_byte;

    assign o_in_ready     = r_state inside {S_IDLE, S_COLLECT, S_DRAIN};
    assign o_crc_start    = r_state == S_START;
    assign o_crc_data     = r_data;
    assign o_result_valid = r_state == S_RESULT;
    assign o_result       = r_result;
    assign o_err_len      = r_err_len;
    assign o_err_timeout  = r_err_to;

    assign w_xfer      = i_in_valid && o_in_ready;
    assign w_last_byte = r_idx == r_len - 8'd1;
    assign w_last_bit  = r_cnt == CW'({r_len, 3'b111});
    assign w_timeout   = r_cnt == CW'(DONE_TIMEOUT - 1);
    // r_cnt restarts on every state change so each phase counts from zero
    assign w_count     = r_state inside {S_SHIFT, S_PAD, S_WAIT} && w_next == r_state;
    assign w_cnt_nx    = w_count ? r_cnt + 1'b1 : '0;
    assign w_bsel      = w_cnt_nx[CW-1:3];
    assign w_byte      = (w_bsel == '0) ? r_len : r_buf[IW'(w_bsel - 1'b1)];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_xfer) w_next = i_in_byte == 8'd0 ? S_START :
                                            i_in_byte > 8'(MAX_BYTES) ? S_DRAIN : S_COLLECT;
            S_COLLECT: if (w_xfer && w_last_byte) w_next = S_START;
            S_DRAIN:   if (w_xfer && w_last_byte) w_next = S_RESULT;
            S_START:   w_next = S_SHIFT;
            S_SHIFT:   if (w_last_bit) w_next = S_PAD;
            S_PAD:     if (r_cnt == CW'(15)) w_next = S_WAIT;
            S_WAIT:    if (i_crc_done || w_timeout) w_next = S_RESULT;
            S_RESULT:  if (i_result_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clock) begin
        if (r_state == S_COLLECT && w_xfer) r_buf[IW'(r_idx)] <= i_in_byte;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_len    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_data   <= 1'b0;
            r_result <= '0;
            r_err_len <= 1'b0;
            r_err_to <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nx;
            r_data <= w_next == S_SHIFT && w_byte[~w_cnt_nx[2:0]];
            if (r_state == S_IDLE) r_idx <= '0;
            else if (w_xfer)       r_idx <= r_idx + 8'd1;
            if (r_state == S_IDLE && w_xfer) r_len <= i_in_byte;
            if (r_state == S_DRAIN && w_next == S_RESULT) r_err_len <= 1'b1;
            if (r_state == S_WAIT && i_crc_done)     r_result <= i_crc_r;
            else if (r_state == S_WAIT && w_timeout) r_err_to <= 1'b1;
            if (r_state == S_RESULT && i_result_ready) begin
                r_result  <= '0;
                r_err_len <= 1'b0;
                r_err_to  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_crc_packet_ctrl.sv
// tb_crc_packet_ctrl: table-driven packet vectors plus reset and early-done corner sequences
module tb_crc_packet_ctrl;
    localparam int MAXB = 16;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_byte = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, crc_start, crc_data;
    logic        crc_done = 1'b0;
    logic [15:0] crc_r = '0;
    logic [15:0] result;
    logic        err_len, err_to, result_valid;
    logic        result_ready = 1'b0;

    int nvec = 0;
    int nbad = 0;
    int starts = 0;

    crc_packet_ctrl #(.MAX_BYTES(MAXB), .DONE_TIMEOUT(TMO)) dut (
        .i_clock(clk), .i_reset(rst), .i_in_byte(in_byte), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .o_crc_start(crc_start), .o_crc_data(crc_data),
        .i_crc_done(crc_done), .i_crc_r(crc_r), .o_result(result), .o_err_len(err_len),
        .o_err_timeout(err_to), .o_result_valid(result_valid), .i_result_ready(result_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (crc_start === 1'b1) starts <= starts + 1;

    typedef struct {
        int           n;
        logic [159:0] pay;
        int           gap;
        int           done_dly;
        logic [15:0]  r;
        int           hold;
        bit           early;
        logic [15:0]  exp_res;
        bit           exp_len;
        bit           exp_to;
        int           exp_starts;
    } vec_t;

    vec_t vt [7];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, output bit ok);
        int w = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && w < 100) begin tick(); w++; end
        ok = in_ready;
        if (ok) tick();
        in_valid = 1'b0;
    endtask

    function automatic logic sbit(input vec_t t, input int k);
        logic [7:0] b;
        if (k >= 8 * (t.n + 1)) return 1'b0;
        b = (k < 8) ? t.n[7:0] : t.pay[8 * ((k / 8) - 1) +: 8];
        return b[7 - (k % 8)];
    endfunction

    task automatic send_packet(input vec_t t, input int v);
        bit ok;
        int nok = 0;
        send(8'(t.n), ok);
        if (ok) nok++;
        for (int i = 0; i < t.n; i++) begin
            repeat (t.gap) tick();
            send(t.pay[8 * i +: 8], ok);
            if (ok) nok++;
        end
        check($sformatf("v%0d bytes accepted", v), nok, t.n + 1);
    endtask

    task automatic run_vec(input int v);
        vec_t t;
        int   s0, nbits, bad, first, lat, exp_lat;
        bit   stable;
        t = vt[v];
        s0 = starts;
        nbits = 8 * (t.n + 1) + 16;
        lat = 0;
        exp_lat = 0;
        send_packet(t, v);
        if (t.exp_starts == 1) begin
            check($sformatf("v%0d crc_start", v), crc_start, 1);
            check($sformatf("v%0d start data", v), crc_data, 0);
            bad = 0;
            first = -1;
            for (int j = 0; j < nbits; j++) begin
                if (t.early && j == 10) begin crc_done = 1'b1; crc_r = 16'hDEAD; end
                tick();
                crc_done = 1'b0;
                if (crc_data !== sbit(t, j) || crc_start !== 1'b0) begin
                    bad++;
                    if (first < 0) first = j;
                end
            end
            check($sformatf("v%0d stream bad bits (first at %0d)", v, first), bad, 0);
            if (t.done_dly >= 0) begin
                tick(); lat++;
                repeat (t.done_dly) begin tick(); lat++; end
                crc_done = 1'b1;
                crc_r = t.r;
                tick(); lat++;
                crc_done = 1'b0;
                crc_r = 16'h0F0F;
            end
            exp_lat = t.done_dly >= 0 ? t.done_dly + 2 : TMO + 1;
        end
        while (!result_valid && lat < 300) begin tick(); lat++; end
        check($sformatf("v%0d result latency", v), lat, exp_lat);
        check($sformatf("v%0d result", v), result, t.exp_res);
        check($sformatf("v%0d err_len", v), err_len, t.exp_len);
        check($sformatf("v%0d err_timeout", v), err_to, t.exp_to);
        check($sformatf("v%0d in_ready in result", v), in_ready, 0);
        check($sformatf("v%0d start pulses", v), starts - s0, t.exp_starts);
        if (t.hold > 0) begin
            stable = 1'b1;
            repeat (t.hold) begin
                tick();
                if (result_valid !== 1'b1 || result !== t.exp_res || err_len !== t.exp_len ||
                    err_to !== t.exp_to || in_ready !== 1'b0) stable = 1'b0;
            end
            check($sformatf("v%0d held stable", v), stable, 1);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check($sformatf("v%0d valid after handshake", v), result_valid, 0);
        check($sformatf("v%0d flags after handshake", v), {err_len, err_to}, 0);
        check($sformatf("v%0d in_ready after handshake", v), in_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{n:3,  pay:160'h030201, gap:0, done_dly:3,  r:16'hBEEF, hold:10, early:0,
                  exp_res:16'hBEEF, exp_len:0, exp_to:0, exp_starts:1};
        vt[1] = '{n:3,  pay:160'h030201, gap:3, done_dly:0,  r:16'hBEEF, hold:0,  early:1,
                  exp_res:16'hBEEF, exp_len:0, exp_to:0, exp_starts:1};
        vt[2] = '{n:0,  pay:160'h0, gap:0, done_dly:5, r:16'h1234, hold:2, early:0,
                  exp_res:16'h1234, exp_len:0, exp_to:0, exp_starts:1};
        vt[3] = '{n:20, pay:{20{8'hA5}}, gap:0, done_dly:-1, r:16'h0, hold:3, early:0,
                  exp_res:16'h0, exp_len:1, exp_to:0, exp_starts:0};
        vt[4] = '{n:3,  pay:160'h030201, gap:0, done_dly:-1, r:16'h0, hold:1, early:0,
                  exp_res:16'h0, exp_len:0, exp_to:1, exp_starts:1};
        vt[5] = '{n:16, pay:160'h100F0E0D0C0B0A090807060504030201, gap:1, done_dly:63, r:16'hCAFE,
                  hold:1, early:0, exp_res:16'hCAFE, exp_len:0, exp_to:0, exp_starts:1};
        vt[6] = '{n:17, pay:{20{8'h5A}}, gap:2, done_dly:-1, r:16'h0, hold:0, early:0,
                  exp_res:16'h0, exp_len:1, exp_to:0, exp_starts:0};

        repeat (3) tick();
        check("reset in_ready", in_ready, 1);
        check("reset outputs", {crc_start, crc_data, result_valid, err_len, err_to}, 0);
        check("reset result", result, 0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) run_vec(v);

        send_packet(vt[0], 0);
        check("pre-reset crc_start", crc_start, 1);
        repeat (7) tick();
        check("pre-reset stream bit 6", crc_data, 1);
        rst = 1'b1;
        tick();
        check("mid-shift reset crc_data", crc_data, 0);
        check("mid-shift reset result_valid", result_valid, 0);
        check("mid-shift reset in_ready", in_ready, 1);
        rst = 1'b0;
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
